// File: rtl/matmul_result_drain.sv
// Drains the two C output banks of the matmul through the external BRAM
// port and streams one row per beat over a valid/ready link.
module matmul_result_drain #(
    parameter int DWIDTH            = 8,
    parameter int MAT_MUL_SIZE      = 8,
    parameter int AWIDTH            = 11,
    parameter int ADDR_STRIDE_WIDTH = 8,
    parameter int C_BANK_SEL_BASE   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [AWIDTH-1:0]              base_addr,
    input  logic [ADDR_STRIDE_WIDTH-1:0]   addr_stride,
    input  logic [3:0]                     num_rows,
    output logic                           busy,
    output logic                           done,
    output logic [7:0]                     bram_select,
    output logic [AWIDTH-1:0]              bram_addr,
    output logic [MAT_MUL_SIZE-1:0]        bram_we,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_rdata,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_bank,
    output logic                           out_last
);

    localparam int RW = MAT_MUL_SIZE * DWIDTH;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_BANK_SW = 3'd2;
    localparam logic [2:0] S_FLUSH   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [3:0] MAX_ROWS  = 4'(MAT_MUL_SIZE);
    localparam logic [7:0] SEL_BASE  = 8'(C_BANK_SEL_BASE);

    logic [2:0]        state_q, state_d;
    logic [AWIDTH-1:0] base_q, base_d;
    logic [AWIDTH-1:0] stride_q, stride_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [3:0]        nrows_q, nrows_d;
    logic [3:0]        row_q, row_d;
    logic              bank_q, bank_d;
    logic              infl_q, infl_d;
    logic              infl_bank_q, infl_bank_d;
    logic              infl_last_q, infl_last_d;
    logic [RW-1:0]     fifo_data_q [2];
    logic [RW-1:0]     fifo_data_d [2];
    logic              fifo_bank_q [2];
    logic              fifo_bank_d [2];
    logic              fifo_last_q [2];
    logic              fifo_last_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    logic pop;
    logic issue;
    logic last_row;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        stride_d    = stride_q;
        addr_d      = addr_q;
        nrows_d     = nrows_q;
        row_d       = row_q;
        bank_d      = bank_q;
        fifo_data_d = fifo_data_q;
        fifo_bank_d = fifo_bank_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;

        pop      = (count_q != 2'd0) && out_ready;
        last_row = (row_q == nrows_q - 4'd1);
        // Credit counts the slot freed by a same-cycle pop so the
        // pipeline sustains one read per cycle with a 2-entry FIFO.
        issue    = (state_q == S_ISSUE) &&
                   (({1'b0, count_q} - {2'b0, pop} + {2'b0, infl_q}) < 3'd2);

        infl_d      = issue;
        infl_bank_d = bank_q;
        infl_last_d = bank_q && last_row;

        if (infl_q) begin
            fifo_data_d[wr_ptr_q] = bram_rdata;
            fifo_bank_d[wr_ptr_q] = infl_bank_q;
            fifo_last_d[wr_ptr_q] = infl_last_q;
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, infl_q} - {1'b0, pop};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    stride_d = AWIDTH'(addr_stride);
                    addr_d   = base_addr;
                    nrows_d  = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
                    row_d    = 4'd0;
                    bank_d   = 1'b0;
                    state_d  = (num_rows == 4'd0) ? S_FLUSH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    addr_d = addr_q + stride_q;
                    if (last_row) begin
                        row_d   = 4'd0;
                        state_d = bank_q ? S_FLUSH : S_BANK_SW;
                    end else begin
                        row_d = row_q + 4'd1;
                    end
                end
            end
            S_BANK_SW: begin
                bank_d  = 1'b1;
                row_d   = 4'd0;
                addr_d  = base_q;
                state_d = S_ISSUE;
            end
            S_FLUSH: begin
                if (!infl_q &&
                    (count_q == 2'd0 || (count_q == 2'd1 && pop))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            stride_q    <= '0;
            addr_q      <= '0;
            nrows_q     <= '0;
            row_q       <= '0;
            bank_q      <= 1'b0;
            infl_q      <= 1'b0;
            infl_bank_q <= 1'b0;
            infl_last_q <= 1'b0;
            fifo_data_q <= '{default: '0};
            fifo_bank_q <= '{default: 1'b0};
            fifo_last_q <= '{default: 1'b0};
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            stride_q    <= stride_d;
            addr_q      <= addr_d;
            nrows_q     <= nrows_d;
            row_q       <= row_d;
            bank_q      <= bank_d;
            infl_q      <= infl_d;
            infl_bank_q <= infl_bank_d;
            infl_last_q <= infl_last_d;
            fifo_data_q <= fifo_data_d;
            fifo_bank_q <= fifo_bank_d;
            fifo_last_q <= fifo_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Select follows bank_q, which only flips when leaving BANK_SW.
    assign bram_select = SEL_BASE + {7'd0, bank_q};
    assign bram_addr   = addr_q;
    assign bram_we     = '0;
    assign bram_wdata  = '0;
    assign busy        = (state_q == S_ISSUE) || (state_q == S_BANK_SW) ||
                         (state_q == S_FLUSH);
    assign done        = (state_q == S_DONE);
    assign out_valid   = (count_q != 2'd0);
    assign out_data    = fifo_data_q[rd_ptr_q];
    assign out_bank    = fifo_bank_q[rd_ptr_q];
    assign out_last    = fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_matmul_result_drain.sv
// Scoreboard bench for matmul_result_drain: a two-bank registered BRAM
// model feeds the drain; each accepted beat is checked against a queue.
module tb_matmul_result_drain;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] base_addr;
    logic [7:0]  addr_stride;
    logic [3:0]  num_rows;
    logic        busy;
    logic        done;
    logic [7:0]  bram_select;
    logic [10:0] bram_addr;
    logic [7:0]  bram_we;
    logic [63:0] bram_wdata;
    logic [63:0] bram_rdata;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_bank;
    logic        out_last;

    always #5 clk = ~clk;

    matmul_result_drain dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .addr_stride (addr_stride),
        .num_rows    (num_rows),
        .busy        (busy),
        .done        (done),
        .bram_select (bram_select),
        .bram_addr   (bram_addr),
        .bram_we     (bram_we),
        .bram_wdata  (bram_wdata),
        .bram_rdata  (bram_rdata),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bank    (out_bank),
        .out_last    (out_last)
    );

    typedef struct packed {
        logic [63:0] d;
        logic        b;
        logic        l;
    } beat_t;

    int    compared   = 0;
    int    mismatched = 0;
    int    cyc        = 0;
    beat_t exp_q[$];
    int    beat_cyc[$];
    int    done_cyc[$];
    beat_t e;
    logic  stall_q = 1'b0;
    logic [65:0] hold_q = '0;
    logic [63:0] rd0, rd1;
    logic [3:0]  rpat = 4'b1001;
    int    s;

    // Row contents encode bank and address so misaddressed reads show up.
    function automatic logic [63:0] pat(input logic b, input logic [10:0] a);
        logic [7:0] by;
        by = b ? 8'h80 : 8'h01;
        return {{6{by}}, 5'd0, a};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        rd0 <= pat(1'b0, bram_addr);
        rd1 <= pat(1'b1, bram_addr);
    end
    assign bram_rdata = (bram_select == 8'd5) ? rd1 :
                        (bram_select == 8'd4) ? rd0 : 64'hdead_beef_dead_beef;

    always @(negedge clk) begin
        if (reset) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                compared++;
                assert (out_valid === 1'b1 &&
                        {out_data, out_bank, out_last} === hold_q)
                else begin
                    mismatched++;
                    $error("FAIL stall_hold obs=%0b/%h exp=1/%h", out_valid,
                           {out_data, out_bank, out_last}, hold_q);
                end
            end
            if (out_valid && out_ready) begin
                compared++;
                assert (exp_q.size() > 0)
                else begin
                    mismatched++;
                    $error("FAIL extra_beat obs=%h exp=none", out_data);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    compared++;
                    assert ({out_data, out_bank, out_last} === e)
                    else begin
                        mismatched++;
                        $error("FAIL beat obs=%h/%0b/%0b exp=%h/%0b/%0b",
                               out_data, out_bank, out_last, e.d, e.b, e.l);
                    end
                end
                beat_cyc.push_back(cyc);
            end
            stall_q = out_valid && !out_ready;
            hold_q  = {out_data, out_bank, out_last};
            compared++;
            assert (int'(dut.count_q) + int'(dut.infl_q) <= 2 &&
                    bram_we === 8'd0 && bram_wdata === 64'd0)
            else begin
                mismatched++;
                $error("FAIL occ_or_we obs=%0d/%h/%h exp=<=2/0/0",
                       int'(dut.count_q) + int'(dut.infl_q), bram_we, bram_wdata);
            end
        end
        if (done) done_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic load_exp(input logic [10:0] base, input logic [7:0] stride,
                            input int n);
        logic [10:0] a;
        beat_t       x;
        exp_q.delete();
        beat_cyc.delete();
        done_cyc.delete();
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < n; r++) begin
                a   = base + 11'(r * int'(stride));
                x.d = pat(b[0], a);
                x.b = b[0];
                x.l = (b == 1) && (r == n - 1);
                exp_q.push_back(x);
            end
        end
    endtask

    task automatic pulse_start(input logic [10:0] base, input logic [7:0] stride,
                               input logic [3:0] n, output int sc);
        @(posedge clk);
        #1;
        start       = 1'b1;
        base_addr   = base;
        addr_stride = stride;
        num_rows    = n;
        sc          = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input bit bp);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            out_ready = bp ? rpat[i % 4] : 1'b1;
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                check("busy_at_done", 64'(busy), 64'd0);
                break;
            end
        end
        check("done_seen", 64'(ok), 64'd1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic finish_checks(input int nbeats);
        check("beat_count", 64'(beat_cyc.size()), 64'(nbeats));
        check("exp_left", 64'(exp_q.size()), 64'd0);
        check("done_count", 64'(done_cyc.size()), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        addr_stride = '0;
        num_rows    = '0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_bank", 64'(out_bank), 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_sel", 64'(bram_select), 64'd4);
        check("rst_addr", 64'(bram_addr), 64'd0);
        check("rst_we", 64'(bram_we), 64'd0);
        check("rst_wdata", bram_wdata, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic drain with timing of first beat, bank bubble and done.
        load_exp(11'd0, 8'd8, 8);
        pulse_start(11'd0, 8'd8, 4'd8, s);
        check("issue_addr", 64'(bram_addr), 64'd0);
        check("issue_sel", 64'(bram_select), 64'd4);
        check("busy_after_start", 64'(busy), 64'd1);
        run_until_done(200, 1'b0);
        finish_checks(16);
        if (beat_cyc.size() == 16 && done_cyc.size() == 1) begin
            check("first_beat_cyc", 64'(beat_cyc[0]), 64'(s + 3));
            check("beat8_cyc", 64'(beat_cyc[7]), 64'(s + 10));
            check("bank_bubble", 64'(beat_cyc[8] - beat_cyc[7]), 64'd2);
            check("beat16_cyc", 64'(beat_cyc[15]), 64'(s + 19));
            check("done_after_last", 64'(done_cyc[0] - beat_cyc[15]), 64'd1);
        end

        // Backpressure with ready pattern 1,0,0,1.
        load_exp(11'd0, 8'd8, 8);
        pulse_start(11'd0, 8'd8, 4'd8, s);
        run_until_done(400, 1'b1);
        finish_checks(16);

        // Address wrap.
        load_exp(11'd2040, 8'd8, 2);
        pulse_start(11'd2040, 8'd8, 4'd2, s);
        run_until_done(100, 1'b0);
        finish_checks(4);

        // Row count above the matrix size clamps to 8.
        load_exp(11'd100, 8'd3, 8);
        pulse_start(11'd100, 8'd3, 4'd12, s);
        run_until_done(200, 1'b0);
        finish_checks(16);

        // Zero rows.
        load_exp(11'd0, 8'd8, 0);
        pulse_start(11'd0, 8'd8, 4'd0, s);
        run_until_done(20, 1'b0);
        finish_checks(0);
        if (done_cyc.size() == 1) begin
            check("zero_done_cyc", 64'(done_cyc[0]), 64'(s + 2));
        end

        // Second start at beat 3 with different parameters is ignored.
        load_exp(11'd0, 8'd8, 8);
        pulse_start(11'd0, 8'd8, 4'd8, s);
        repeat (4) @(posedge clk);
        #1;
        start       = 1'b1;
        base_addr   = 11'd16;
        addr_stride = 8'd1;
        num_rows    = 4'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        run_until_done(200, 1'b0);
        finish_checks(16);

        // Reset during beat 5 aborts the drain.
        load_exp(11'd0, 8'd8, 8);
        pulse_start(11'd0, 8'd8, 4'd8, s);
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        exp_q.delete();
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cyc.size()), 64'd0);
        check("abort_beats", 64'(beat_cyc.size()), 64'd4);

        // Fresh drain after the abort.
        load_exp(11'd0, 8'd8, 8);
        pulse_start(11'd0, 8'd8, 4'd8, s);
        run_until_done(200, 1'b0);
        finish_checks(16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
